// File: rtl/jogo_seq_pkg.sv
// jogo_seq_pkg: state codes and sequence ROM contents shared by the sequence game.
package jogo_seq_pkg;
   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      ESPERA      = 4'h2,
      COMPARA     = 4'h4,
      PROXIMA     = 4'h5,
      NOVA_RODADA = 4'h6,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } estado_t;

   // Entry a of the sequence lights key (a mod n); n must not exceed 32.
   function automatic logic [31:0] rom_entry(input int a, input int n);
      return 32'(1) << (a % n);
   endfunction
endpackage

// File: rtl/jogo_sequencia_param_if.sv
// jogo_sequencia_param_if: player keys, start request, results and debug buses of the game.
interface jogo_sequencia_param_if #(
   parameter int N_BOTOES = 4,
   parameter int AW       = 4
);
   logic                iniciar;
   logic [N_BOTOES-1:0] chaves;
   logic                acertou;
   logic                errou;
   logic                timeout;
   logic                pronto;
   logic [N_BOTOES-1:0] leds;
   logic                db_igual;
   logic [AW-1:0]       db_contagem;
   logic [AW-1:0]       db_rodada;
   logic [N_BOTOES-1:0] db_memoria;
   logic [N_BOTOES-1:0] db_jogada;
   logic [3:0]          db_estado;
   logic                db_tem_jogada;

   modport master (
      output iniciar, chaves,
      input  acertou, errou, timeout, pronto, leds, db_igual, db_contagem,
             db_rodada, db_memoria, db_jogada, db_estado, db_tem_jogada
   );

   modport slave (
      input  iniciar, chaves,
      output acertou, errou, timeout, pronto, leds, db_igual, db_contagem,
             db_rodada, db_memoria, db_jogada, db_estado, db_tem_jogada
   );
endinterface

// File: rtl/memoria_rom_jogadas.sv
// memoria_rom_jogadas: PROF x N_BOTOES sequence ROM with combinational read.
module memoria_rom_jogadas
   import jogo_seq_pkg::*;
#(
   parameter int N_BOTOES = 4,
   parameter int PROF     = 16,
   localparam int AW      = $clog2(PROF)
) (
   input  logic [AW-1:0]       endereco,
   output logic [N_BOTOES-1:0] dado
);
   logic [N_BOTOES-1:0] mem [PROF];

   for (genvar i = 0; i < PROF; i++) begin : g_rom
      assign mem[i] = N_BOTOES'(rom_entry(i, N_BOTOES));
   end

   assign dado = mem[endereco];
endmodule

// File: rtl/jogo_sequencia_param.sv
// jogo_sequencia_param: memory-sequence game growing one entry per round, with
// per-play timeout and key edge detection.
module jogo_sequencia_param
   import jogo_seq_pkg::*;
#(
   parameter int N_BOTOES = 4,
   parameter int PROF     = 16,
   parameter int TIMEOUT  = 5000
) (
   input logic              clock,
   input logic              reset,
   jogo_sequencia_param_if.slave bus
);
   localparam int AW = $clog2(PROF);
   localparam int TW = $clog2(TIMEOUT + 1);

   estado_t             estado, prox;
   logic [AW-1:0]       contagem, rodada;
   logic [N_BOTOES-1:0] jogada, chaves_prev, memoria;
   logic [TW-1:0]       timer;
   logic                igual, jogada_feita, fim_tempo;

   memoria_rom_jogadas #(.N_BOTOES(N_BOTOES), .PROF(PROF)) rom (
      .endereco(contagem),
      .dado    (memoria)
   );

   // A held key counts once: only the transition from no key to some key is a play.
   assign jogada_feita = (|bus.chaves) && !(|chaves_prev);
   assign igual        = jogada == memoria;
   assign fim_tempo    = timer == TW'(TIMEOUT - 1);

   always_ff @(posedge clock)
      if (reset) estado <= INICIAL;
      else       estado <= prox;

   always_comb begin
      prox = estado;
      case (estado)
         INICIAL:     prox = bus.iniciar ? PREPARA : INICIAL;
         PREPARA:     prox = ESPERA;
         ESPERA:      prox = jogada_feita ? COMPARA : fim_tempo ? FIM_TIMEOUT : ESPERA;
         COMPARA:     prox = !igual ? FIM_ERRO :
                             contagem < rodada ? PROXIMA :
                             rodada == AW'(PROF - 1) ? FIM_ACERTO : NOVA_RODADA;
         PROXIMA:     prox = ESPERA;
         NOVA_RODADA: prox = ESPERA;
         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: prox = bus.iniciar ? PREPARA : estado;
         default:     prox = INICIAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         contagem    <= '0;
         rodada      <= '0;
         jogada      <= '0;
         chaves_prev <= '0;
         timer       <= '0;
      end else begin
         chaves_prev <= bus.chaves;
         if (estado == PREPARA) begin
            contagem <= '0;
            rodada   <= '0;
            jogada   <= '0;
            timer    <= '0;
         end
         if (estado == ESPERA) begin
            timer <= (timer == {TW{1'b1}}) ? timer : timer + 1'b1;
            if (jogada_feita) jogada <= bus.chaves;
         end
         if (estado == PROXIMA) begin
            contagem <= contagem + 1'b1;
            timer    <= '0;
         end
         if (estado == NOVA_RODADA) begin
            rodada   <= rodada + 1'b1;
            contagem <= '0;
            timer    <= '0;
         end
      end
   end

   assign bus.acertou       = estado == FIM_ACERTO;
   assign bus.errou         = (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
   assign bus.timeout       = estado == FIM_TIMEOUT;
   assign bus.pronto        = (estado == FIM_ACERTO) || (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
   assign bus.leds          = bus.chaves;
   assign bus.db_igual      = igual;
   assign bus.db_contagem   = contagem;
   assign bus.db_rodada     = rodada;
   assign bus.db_memoria    = memoria;
   assign bus.db_jogada     = jogada;
   assign bus.db_estado     = estado;
   assign bus.db_tem_jogada = jogada_feita;
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// tb_jogo_sequencia_param: directed and random games checked against a round/index game model.
module tb_jogo_sequencia_param;
   localparam int N  = 4;
   localparam int P  = 4;
   localparam int TO = 20;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   jogo_sequencia_param_if #(.N_BOTOES(N), .AW(2)) bus ();

   jogo_sequencia_param #(.N_BOTOES(N), .PROF(P), .TIMEOUT(TO)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   int m_round, m_idx;

   always @(negedge clock) if (bus.db_tem_jogada) pulses++;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int seq_key(input int i);
      return 1 << (i % N);
   endfunction

   task automatic flags(input string tag, input int pr, input int ac, input int er, input int tm);
      check({tag, "_pronto"}, int'(bus.pronto), pr);
      check({tag, "_acertou"}, int'(bus.acertou), ac);
      check({tag, "_errou"}, int'(bus.errou), er);
      check({tag, "_timeout"}, int'(bus.timeout), tm);
   endtask

   task automatic start_game();
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      tick();
      m_round = 0;
      m_idx   = 0;
      check("start_estado", int'(bus.db_estado), 2);
      check("start_rodada", int'(bus.db_rodada), 0);
      check("start_contagem", int'(bus.db_contagem), 0);
      check("start_jogada", int'(bus.db_jogada), 0);
      flags("start", 0, 0, 0, 0);
   endtask

   task automatic play(input logic [3:0] key, input int gap, input int hold, output bit ended);
      int esperado, es;
      ended = 0;
      repeat (gap) tick();
      check("wait_estado", int'(bus.db_estado), 2);
      check("wait_contagem", int'(bus.db_contagem), m_idx);
      check("wait_rodada", int'(bus.db_rodada), m_round);
      bus.chaves = key;
      tick();
      tick();
      esperado = seq_key(m_idx);
      if (int'(key) != esperado) begin
         es = 14;
         ended = 1;
         flags("erro", 1, 0, 1, 0);
         check("erro_memoria", int'(bus.db_memoria), esperado);
         check("erro_jogada", int'(bus.db_jogada), int'(key));
      end else if (m_idx < m_round) begin
         es = 5;
         m_idx++;
         flags("proxima", 0, 0, 0, 0);
      end else if (m_round == P - 1) begin
         es = 10;
         ended = 1;
         flags("acerto", 1, 1, 0, 0);
         check("acerto_rodada", int'(bus.db_rodada), P - 1);
      end else begin
         es = 6;
         m_round++;
         m_idx = 0;
         flags("nova", 0, 0, 0, 0);
      end
      check("play_estado", int'(bus.db_estado), es);
      repeat (hold) tick();
      bus.chaves = '0;
      tick();
      if (ended) check("fim_hold", int'(bus.db_estado), es);
   endtask

   task automatic do_timeout();
      repeat (TO - 1) tick();
      check("to_edge_estado", int'(bus.db_estado), 2);
      check("to_edge_timeout", int'(bus.timeout), 0);
      tick();
      check("to_estado", int'(bus.db_estado), 13);
      flags("to", 1, 0, 1, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ended, fresh;
      int h, p0;
      logic [3:0] key;
      reset = 1'b1;
      bus.iniciar = 1'b0;
      bus.chaves = '0;
      repeat (2) tick();
      flags("reset", 0, 0, 0, 0);
      check("reset_estado", int'(bus.db_estado), 0);
      check("reset_rodada", int'(bus.db_rodada), 0);
      check("reset_contagem", int'(bus.db_contagem), 0);
      reset = 1'b0;
      tick();
      check("idle_estado", int'(bus.db_estado), 0);

      start_game();
      for (int r = 0; r < P; r++)
         for (int i = 0; i <= r; i++) play(4'(seq_key(i)), 0, 0, ended);
      check("full_ended", int'(ended), 1);

      start_game();
      p0 = pulses;
      play(4'b0001, 0, 8, ended);
      check("hold_pulses", pulses - p0, 1);
      play(4'b0001, 0, 0, ended);
      play(4'b0100, 0, 0, ended);
      check("erro_ended", int'(ended), 1);

      start_game();
      do_timeout();

      start_game();
      play(4'b0001, 0, 0, ended);
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      check("ign_estado", int'(bus.db_estado), 2);
      check("ign_rodada", int'(bus.db_rodada), 1);
      play(4'b0001, 0, 0, ended);
      play(4'b0010, 0, 0, ended);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_estado", int'(bus.db_estado), 0);
      check("midrst_rodada", int'(bus.db_rodada), 0);
      check("midrst_contagem", int'(bus.db_contagem), 0);
      flags("midrst", 0, 0, 0, 0);
      tick();
      check("midrst_idle", int'(bus.db_estado), 0);

      for (int g = 0; g < 12; g++) begin
         ended = 0;
         fresh = 1;
         start_game();
         while (!ended) begin
            if (fresh && $urandom_range(0, 9) == 0) begin
               do_timeout();
               ended = 1;
            end else begin
               h = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
               key = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'(seq_key(m_idx));
               play(key, int'($urandom_range(0, 3)), h, ended);
               fresh = (h == 0);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
